// File: rtl/soc_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_timer_pkg
// Brief    : Register map and bit positions of the soc_timer peripheral.
// Revision : 1.0
// ============================================================================
package soc_timer_pkg;

    // Word index, i.e. iomem_addr[4:2]
    localparam logic [2:0] c_REG_CTRL     = 3'd0;
    localparam logic [2:0] c_REG_PRESCALE = 3'd1;
    localparam logic [2:0] c_REG_RELOAD   = 3'd2;
    localparam logic [2:0] c_REG_COUNT    = 3'd3;
    localparam logic [2:0] c_REG_STATUS   = 3'd4;

    localparam int c_CTRL_EN          = 0;
    localparam int c_CTRL_AUTO        = 1;
    localparam int c_CTRL_IE          = 2;
    localparam int c_STATUS_EXPIRED   = 0;

    function automatic logic [31:0] merge_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : soc_timer_prescaler
// Brief    : Free-running 0..PRESCALE counter emitting a one-cycle tick.
// Revision : 1.0
// ============================================================================
module soc_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  w_hit;

    // >= so that lowering PRESCALE below the running count ends the period
    // instead of letting the counter wrap through its full range.
    assign w_hit  = (r_cnt >= i_prescale);
    assign o_tick = i_en & w_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_timer.sv
`default_nettype none
// ============================================================================
// Module   : soc_timer
// Brief    : iomem-mapped 32-bit down-counting timer with prescaler and irq.
// Revision : 1.0
// ============================================================================
module soc_timer
    import soc_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    output logic        irq
);

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_en;
    logic                  r_auto;
    logic                  r_ie;
    logic                  r_expired;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_reload;
    logic [31:0]           r_count;

    logic        w_acc;
    logic        w_wr;
    logic [2:0]  w_sel;
    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_reload;
    logic        w_wr_count;
    logic        w_wr_status;
    logic [31:0] w_ctrl_cur;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_status_cur;
    logic [31:0] w_presc_cur;
    logic [31:0] w_presc_new;
    logic [31:0] w_rd_val;
    logic        w_en_rise;
    logic        w_tick;
    logic        w_tick_eff;
    logic        w_expire;
    logic        w_status_clr;
    logic        w_unused;

    assign w_acc       = iomem_valid & ~r_ready;
    assign w_wr        = w_acc & (|iomem_wstrb);
    assign w_sel       = iomem_addr[4:2];
    assign w_wr_ctrl   = w_wr & (w_sel == c_REG_CTRL);
    assign w_wr_presc  = w_wr & (w_sel == c_REG_PRESCALE);
    assign w_wr_reload = w_wr & (w_sel == c_REG_RELOAD);
    assign w_wr_count  = w_wr & (w_sel == c_REG_COUNT);
    assign w_wr_status = w_wr & (w_sel == c_REG_STATUS);

    always_comb begin
        w_ctrl_cur                    = '0;
        w_ctrl_cur[c_CTRL_EN]         = r_en;
        w_ctrl_cur[c_CTRL_AUTO]       = r_auto;
        w_ctrl_cur[c_CTRL_IE]         = r_ie;
        w_status_cur                  = '0;
        w_status_cur[c_STATUS_EXPIRED] = r_expired;
    end

    assign w_presc_cur = 32'(r_prescale);
    assign w_ctrl_new  = merge_wstrb(w_ctrl_cur, iomem_wdata, iomem_wstrb);
    assign w_presc_new = merge_wstrb(w_presc_cur, iomem_wdata, iomem_wstrb);

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            c_REG_CTRL:     w_rd_val = w_ctrl_cur;
            c_REG_PRESCALE: w_rd_val = w_presc_cur;
            c_REG_RELOAD:   w_rd_val = r_reload;
            c_REG_COUNT:    w_rd_val = r_count;
            c_REG_STATUS:   w_rd_val = w_status_cur;
            default:        w_rd_val = '0;
        endcase
    end

    assign w_en_rise = w_wr_ctrl & w_ctrl_new[c_CTRL_EN] & ~r_en;

    soc_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .resetn     (resetn),
        .i_en       (r_en),
        .i_clr      (w_en_rise),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // A same-cycle COUNT write, or a CTRL write that stops the timer,
    // consumes the tick entirely.
    assign w_tick_eff   = w_tick & ~w_wr_count & ~(w_wr_ctrl & ~w_ctrl_new[c_CTRL_EN]);
    assign w_expire     = w_tick_eff & (r_count == 32'd0);
    assign w_status_clr = w_wr_status & iomem_wstrb[0] & iomem_wdata[c_STATUS_EXPIRED];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_expired  <= 1'b0;
            r_prescale <= '0;
            r_reload   <= '0;
            r_count    <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd_val : 32'd0;

            if (w_wr_ctrl) begin
                r_en   <= w_ctrl_new[c_CTRL_EN];
                r_auto <= w_ctrl_new[c_CTRL_AUTO];
                r_ie   <= w_ctrl_new[c_CTRL_IE];
            end else if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_presc) begin
                r_prescale <= w_presc_new[PRESCALE_W-1:0];
            end

            if (w_wr_reload) begin
                r_reload <= merge_wstrb(r_reload, iomem_wdata, iomem_wstrb);
            end

            if (w_wr_count) begin
                r_count <= merge_wstrb(r_count, iomem_wdata, iomem_wstrb);
            end else if (w_tick_eff) begin
                if (r_count != 32'd0) r_count <= r_count - 32'd1;
                else if (r_auto)      r_count <= r_reload;
            end

            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (w_status_clr) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_expired & r_ie;

    assign w_unused = ^{iomem_addr[31:5], iomem_addr[1:0], w_ctrl_new[31:3], w_presc_new};

endmodule
`default_nettype wire

// File: tb/tb_soc_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_timer
// Brief    : Self-checking bench for soc_timer against a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_soc_timer;

    localparam int PW = 16;
    localparam logic [31:0] PMASK = (32'd1 << PW) - 32'd1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic        irq;

    soc_timer #(.PRESCALE_W(PW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .iomem_ready (iomem_ready),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Architectural state of the timer as firmware sees it.
    bit          m_en, m_auto, m_ie, m_exp, m_ready;
    logic [31:0] m_presc, m_reload, m_count, m_pcnt, m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_ready = 0;
        m_presc = 0; m_reload = 0; m_count = 0; m_pcnt = 0; m_rdata = 0;
    endtask

    // Advance one clock: evaluate the model on the stable inputs, then let the edge happen.
    task automatic step();
        bit          n_en, n_auto, n_ie, n_exp, n_ready;
        logic [31:0] n_presc, n_reload, n_count, n_pcnt, n_rdata, rd, cnew, ctrl;
        int          sel;
        bit          acc, wr, tick, tick_used, expire, stop_wr;
        n_en = m_en; n_auto = m_auto; n_ie = m_ie; n_exp = m_exp;
        n_presc = m_presc; n_reload = m_reload; n_count = m_count;
        sel  = int'(iomem_addr[4:2]);
        acc  = iomem_valid && !m_ready;
        wr   = acc && (iomem_wstrb != 4'd0);
        ctrl = {29'd0, m_ie, m_auto, m_en};
        case (sel)
            0: rd = ctrl;
            1: rd = m_presc;
            2: rd = m_reload;
            3: rd = m_count;
            4: rd = {31'd0, m_exp};
            default: rd = 32'd0;
        endcase
        n_ready = acc;
        n_rdata = acc ? rd : 32'd0;
        cnew    = bytes_merge(ctrl, iomem_wdata, iomem_wstrb);
        stop_wr = wr && sel == 0 && !cnew[0];
        tick    = m_en && (m_pcnt >= m_presc);
        tick_used = tick && !stop_wr && !(wr && sel == 3);
        expire  = 0;
        // Timer event first, then the bus write overrides whatever it touches.
        if (tick_used) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                expire = 1;
                n_exp  = 1;
                if (m_auto) n_count = m_reload;
                else        n_en = 0;
            end
        end
        if (wr) begin
            case (sel)
                0: begin n_en = cnew[0]; n_auto = cnew[1]; n_ie = cnew[2]; end
                1: n_presc  = bytes_merge(m_presc, iomem_wdata, iomem_wstrb) & PMASK;
                2: n_reload = bytes_merge(m_reload, iomem_wdata, iomem_wstrb);
                3: n_count  = bytes_merge(m_count, iomem_wdata, iomem_wstrb);
                4: if (iomem_wstrb[0] && iomem_wdata[0] && !expire) n_exp = 0;
                default: ;
            endcase
        end
        n_pcnt = (!m_en || tick) ? 32'd0 : m_pcnt + 1;
        @(posedge clk);
        if (!resetn) model_reset();
        else begin
            m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp; m_ready = n_ready;
            m_presc = n_presc; m_reload = n_reload; m_count = n_count; m_pcnt = n_pcnt;
            m_rdata = n_rdata;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic access(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data, output logic [31:0] rdat);
        iomem_valid = 1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = data;
        step();
        rdat = iomem_rdata;
        step();
        iomem_valid = 0; iomem_wstrb = 0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        access(addr, 4'hF, data, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        access(addr, 4'h0, 32'd0, v);
    endtask

    task automatic wait_irq(input int bound, output int at);
        int k;
        k = 0;
        while (!irq && k < bound) begin
            step();
            k++;
        end
        at = cyc;
    endtask

    always @(negedge clk) begin
        check("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
        check("rdata", iomem_rdata, m_rdata);
        check("irq",   {31'd0, irq}, {31'd0, m_exp & m_ie});
    end

    initial begin
        logic [31:0] v, addr, data;
        logic [3:0]  strb;
        int          t, a1, a2;

        model_reset();
        repeat (3) step();
        resetn = 1;

        // All offsets read zero out of reset
        for (int i = 0; i < 8; i++) begin
            rd(32'h0800_0000 + 32'(i * 4), v);
            check("reset_read", v, 32'd0);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);

        // One-shot: COUNT=3 expires on the 4th tick after enable
        wr(32'h04, 0);
        wr(32'h0C, 3);
        wr(32'h00, 32'h5);
        t = cyc - 1;
        wait_irq(40, a1);
        check("oneshot_delay", 32'(a1 - t), 32'd4);
        rd(32'h00, v);
        check("oneshot_ctrl", v, 32'h4);
        rd(32'h0C, v);
        check("oneshot_count", v, 32'd0);
        rd(32'h10, v);
        check("oneshot_status", v, 32'd1);
        wr(32'h10, 1);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        // Periodic: 10-clock ticks, 5 ticks per period
        wr(32'h04, 9);
        wr(32'h08, 4);
        wr(32'h0C, 4);
        wr(32'h00, 32'h7);
        t = cyc - 1;
        wait_irq(200, a1);
        check("period_first", 32'(a1 - t), 32'd50);
        wr(32'h10, 1);
        check("period_w1c", {31'd0, irq}, 32'd0);
        wait_irq(200, a2);
        check("period_repeat", 32'(a2 - a1), 32'd50);
        wr(32'h10, 1);
        // Land the next W1C on the expiry edge itself
        while (cyc < a2 + 49) step();
        wr(32'h10, 1);
        check("clear_vs_expire_irq", {31'd0, irq}, 32'd1);
        rd(32'h10, v);
        check("clear_vs_expire_status", v, 32'd1);

        // Byte-lane write
        wr(32'h00, 0);
        wr(32'h08, 0);
        access(32'h08, 4'b0010, 32'hAABB_CCDD, v);
        rd(32'h08, v);
        check("byte_write", v, 32'h0000_CC00);
        wr(32'h10, 1);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                step();
            end else begin
                addr = $urandom();
                strb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                case (addr[4:2])
                    3'd1:       data = 32'($urandom_range(0, 4));
                    3'd2, 3'd3: data = 32'($urandom_range(0, 8));
                    default:    data = $urandom();
                endcase
                access(addr, strb, data, v);
            end
        end

        // Asynchronous reset in the middle of a countdown and an access
        wr(32'h04, 0);
        wr(32'h08, 5);
        wr(32'h0C, 5);
        wr(32'h00, 32'h7);
        wait_irq(40, a1);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        iomem_valid = 1; iomem_addr = 32'h0C; iomem_wstrb = 0;
        step();
        #2;
        resetn = 0;
        model_reset();
        #1;
        check("async_rst_irq",   {31'd0, irq}, 32'd0);
        check("async_rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("async_rst_rdata", iomem_rdata, 32'd0);
        check("async_rst_count", dut.r_count, 32'd0);
        iomem_valid = 0;
        repeat (2) step();
        resetn = 1;
        rd(32'h0C, v);
        check("post_rst_count", v, 32'd0);
        rd(32'h00, v);
        check("post_rst_ctrl", v, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
